// File: rtl/uart_command_rx_pkg.sv
// Shared definitions for the UART command receiver: ASCII codes used by the
// line format, byte-receiver and parser encodings, and the field count that
// is shared with the four-value monitor line format.
package uart_command_rx_pkg;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_NINE  = 8'h39;

  // Number of values per line (same as the monitor output line).
  localparam logic [2:0] FIELD_CNT = 3'd4;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  typedef enum logic [2:0] {
    CH_DIGIT = 3'd0,
    CH_MINUS = 3'd1,
    CH_SPACE = 3'd2,
    CH_CR    = 3'd3,
    CH_LF    = 3'd4,
    CH_OTHER = 3'd5
  } char_class_e;

  // Map a received byte onto the token classes the parser acts on.
  function automatic char_class_e classify(input logic [7:0] b);
    char_class_e c;
    if ((b >= ASCII_ZERO) && (b <= ASCII_NINE)) c = CH_DIGIT;
    else if (b == ASCII_MINUS)                  c = CH_MINUS;
    else if (b == ASCII_SPACE)                  c = CH_SPACE;
    else if (b == ASCII_CR)                     c = CH_CR;
    else if (b == ASCII_LF)                     c = CH_LF;
    else                                        c = CH_OTHER;
    return c;
  endfunction

endpackage

// File: rtl/uart_command_rx_if.sv
// Result bundle of the UART command receiver: accepted-line pulse, the four
// signed field values of the last good line, and the malformed-line pulse.
interface uart_command_rx_if;

  logic               o_en;
  logic signed [15:0] o_val0;
  logic signed [15:0] o_val1;
  logic signed [15:0] o_val2;
  logic signed [15:0] o_val3;
  logic               o_err;

  modport master (output o_en, o_val0, o_val1, o_val2, o_val3, o_err);
  modport slave  (input  o_en, o_val0, o_val1, o_val2, o_val3, o_err);

endinterface

// File: rtl/uart_rx_byte.sv
// 8-N-1 UART byte receiver: two-flop synchronizer, falling-edge start
// detection with mid-bit start re-check, LSB-first data sampling and stop-bit
// framing check. Emits the byte with a one-cycle valid, or a one-cycle
// frame_err when the stop bit reads low.
module uart_rx_byte
  import uart_command_rx_pkg::*;
#(
  parameter logic [15:0] CLK_DIV = 16'd217
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_valid,
  output logic       o_frame_err
);

  localparam logic [15:0] HALF_M1 = (CLK_DIV >> 1) - 16'd1;
  localparam logic [15:0] FULL_M1 = CLK_DIV - 16'd1;

  logic        sync1_q, sync2_q, prev_q;
  logic [1:0]  fill_q, fill_d;
  rx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  byte_q, byte_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        fall_s;

  // Synchronizer and edge-history flops; idle-high reset so no false start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      fill_q  <= 2'd0;
    end else begin
      sync1_q <= i_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      fill_q  <= fill_d;
    end
  end

  // Start edges count only once the history holds real line samples, so a
  // line held low through reset release needs a genuine high-to-low edge.
  always_comb begin
    fill_d = (fill_q == 2'd3) ? fill_q : (fill_q + 2'd1);
    fall_s = (fill_q == 2'd3) && prev_q && !sync2_q;
  end

  // Receiver state, bit timer, shift register and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= RX_IDLE;
      cnt_q   <= 16'd0;
      bit_q   <= 3'd0;
      sh_q    <= 8'd0;
      byte_q  <= 8'd0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state: wait for edge, confirm start at half bit, sample bits, check stop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = 16'd0;
        bit_d = 3'd0;
        if (fall_s) state_d = RX_START;
        else        state_d = RX_IDLE;
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = 16'd0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = 16'd0;
          sh_d    = {sync2_q, sh_q[7:1]};
          bit_d   = bit_q + 3'd1;
          state_d = (bit_q == 3'd7) ? RX_STOP : RX_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = 16'd0;
          state_d = RX_IDLE;
          if (sync2_q) begin
            valid_d = 1'b1;
            byte_d  = sh_q;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign o_byte      = byte_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;

endmodule

// File: rtl/uart_command_rx.sv
// UART command line receiver: parses "a b c d\n" lines of signed decimal
// integers into four signed 16-bit values with a one-cycle o_en pulse, or an
// o_err pulse for malformed lines.
// Optional build macro UART_CMD_RX_SAT_EN: overflowing fields clamp to
// 32767 / -32768 instead of wrapping modulo 2^16.
module uart_command_rx
  import uart_command_rx_pkg::*;
#(
  parameter logic [15:0] CLK_DIV = 16'd217
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                i_uart_rx,
  uart_command_rx_if.master   cmd
);

  logic [7:0] byte_s;
  logic       byte_valid_s;
  logic       frame_err_s;

  uart_rx_byte #(.CLK_DIV(CLK_DIV)) u_byte (
    .clk         (clk),
    .rstn        (rstn),
    .i_rx        (i_uart_rx),
    .o_byte      (byte_s),
    .o_valid     (byte_valid_s),
    .o_frame_err (frame_err_s)
  );

  logic [15:0]        acc_q, acc_d;
  logic               neg_q, neg_d;
  logic               dig_q, dig_d;
  logic [2:0]         fidx_q, fidx_d;
  logic               bad_q, bad_d;
  logic signed [15:0] stg_q [4];
  logic signed [15:0] stg_d [4];
  logic signed [15:0] val_q [4];
  logic signed [15:0] val_d [4];
  logic               en_q, en_d;
  logic               err_q, err_d;
  logic               commit_s, eol_s;
  logic [3:0]         dval_s;
  logic signed [15:0] field_val_s;
`ifdef UART_CMD_RX_SAT_EN
  logic               ovf_q, ovf_d;
  logic [20:0]        prod_s;
`else
  logic [15:0]        prod_s;
`endif

  // Line-parser state and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q  <= 16'd0;
      neg_q  <= 1'b0;
      dig_q  <= 1'b0;
      fidx_q <= 3'd0;
      bad_q  <= 1'b0;
      en_q   <= 1'b0;
      err_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        stg_q[i] <= 16'sd0;
        val_q[i] <= 16'sd0;
      end
    end else begin
      acc_q  <= acc_d;
      neg_q  <= neg_d;
      dig_q  <= dig_d;
      fidx_q <= fidx_d;
      bad_q  <= bad_d;
      en_q   <= en_d;
      err_q  <= err_d;
      stg_q  <= stg_d;
      val_q  <= val_d;
    end
  end

`ifdef UART_CMD_RX_SAT_EN
  // Sticky overflow of the field magnitude, used only for clamping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end
`endif

  // Signed value of the field being committed.
  always_comb begin
`ifdef UART_CMD_RX_SAT_EN
    if (ovf_q)      field_val_s = neg_q ? 16'sh8000 : 16'sh7FFF;
    else if (neg_q) field_val_s = 16'sd0 - $signed(acc_q);
    else            field_val_s = $signed(acc_q);
`else
    if (neg_q) field_val_s = 16'sd0 - $signed(acc_q);
    else       field_val_s = $signed(acc_q);
`endif
  end

  // Parser: consume one byte per clock, commit fields, finalize on LF.
  always_comb begin
    acc_d    = acc_q;
    neg_d    = neg_q;
    dig_d    = dig_q;
    fidx_d   = fidx_q;
    bad_d    = bad_q;
    stg_d    = stg_q;
    val_d    = val_q;
    en_d     = 1'b0;
    err_d    = 1'b0;
    commit_s = 1'b0;
    eol_s    = 1'b0;
    dval_s   = byte_s[3:0];
`ifdef UART_CMD_RX_SAT_EN
    ovf_d    = ovf_q;
    prod_s   = {5'd0, acc_q} * 21'd10 + {17'd0, dval_s};
`else
    prod_s   = acc_q * 16'd10 + {12'd0, dval_s};
`endif

    if (frame_err_s) begin
      bad_d = 1'b1;
    end else if (byte_valid_s) begin
      case (classify(byte_s))
        CH_DIGIT: begin
          acc_d = prod_s[15:0];
          dig_d = 1'b1;
`ifdef UART_CMD_RX_SAT_EN
          if (prod_s > (neg_q ? 21'd32768 : 21'd32767)) ovf_d = 1'b1;
          else                                          ovf_d = ovf_q;
`endif
        end
        CH_MINUS: begin
          if (!dig_q && !neg_q) neg_d = 1'b1;
          else                  bad_d = 1'b1;
        end
        CH_SPACE: begin
          if (dig_q)      commit_s = 1'b1;
          else if (neg_q) bad_d    = 1'b1;
          else            bad_d    = bad_q;
        end
        CH_LF: begin
          eol_s = 1'b1;
          if (dig_q)      commit_s = 1'b1;
          else if (neg_q) bad_d    = 1'b1;
          else            bad_d    = bad_q;
        end
        CH_CR:   bad_d = bad_q;
        default: bad_d = 1'b1;
      endcase
    end else begin
      bad_d = bad_q;
    end

    if (commit_s) begin
      if (fidx_q == FIELD_CNT) begin
        bad_d = 1'b1;
      end else begin
        stg_d[fidx_q[1:0]] = field_val_s;
        fidx_d             = fidx_q + 3'd1;
      end
      acc_d = 16'd0;
      neg_d = 1'b0;
      dig_d = 1'b0;
`ifdef UART_CMD_RX_SAT_EN
      ovf_d = 1'b0;
`endif
    end else begin
      fidx_d = fidx_d;
    end

    if (eol_s) begin
      if (!bad_d && (fidx_d == FIELD_CNT)) begin
        en_d  = 1'b1;
        val_d = stg_d;
      end else begin
        err_d = 1'b1;
      end
      acc_d  = 16'd0;
      neg_d  = 1'b0;
      dig_d  = 1'b0;
      fidx_d = 3'd0;
      bad_d  = 1'b0;
`ifdef UART_CMD_RX_SAT_EN
      ovf_d  = 1'b0;
`endif
    end else begin
      err_d = 1'b0;
    end
  end

  assign cmd.o_en   = en_q;
  assign cmd.o_err  = err_q;
  assign cmd.o_val0 = val_q[0];
  assign cmd.o_val1 = val_q[1];
  assign cmd.o_val2 = val_q[2];
  assign cmd.o_val3 = val_q[3];

endmodule

// File: tb/tb_uart_command_rx.sv
// Directed self-checking bench for uart_command_rx at CLK_DIV = 16.
// Honours UART_CMD_RX_SAT_EN for the overflow expectations.
module tb_uart_command_rx;

  localparam int DIV = 16;

  logic clk;
  logic rstn;
  logic rx;

  uart_command_rx_if cmd_if ();

  uart_command_rx #(.CLK_DIV(16'd16)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .i_uart_rx (rx),
    .cmd       (cmd_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Event monitor
  int          en_cnt   = 0;
  int          err_cnt  = 0;
  int          byte_cnt = 0;
  int          both_cnt = 0;
  int          chg_cnt  = 0;
  logic [63:0] prev_vals = 64'd0;
  logic [63:0] cur_vals;

  assign cur_vals = {cmd_if.o_val0, cmd_if.o_val1, cmd_if.o_val2, cmd_if.o_val3};

  always @(negedge clk) begin
    if (cmd_if.o_en) en_cnt++;
    if (cmd_if.o_err) err_cnt++;
    if (cmd_if.o_en && cmd_if.o_err) both_cnt++;
    if (dut.u_byte.o_valid) byte_cnt++;
    if (rstn && !cmd_if.o_en && (cur_vals !== prev_vals)) chg_cnt++;
    prev_vals = cur_vals;
  end

  task automatic clear_counts();
    en_cnt   = 0;
    err_cnt  = 0;
    byte_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop;
    repeat (DIV) @(negedge clk);
    if (!stop) begin
      rx = 1'b1;
      repeat (DIV) @(negedge clk);
    end
  endtask

  task automatic send_line(input string s, input int bad_idx);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], (i == bad_idx) ? 1'b0 : 1'b1);
    repeat (30) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    rx   = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (cmd_if.o_en !== 1'b0) begin n_fail++; $display("FAIL reset_en got %b want 0", cmd_if.o_en); end
    n_checks++;
    if (cmd_if.o_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", cmd_if.o_err); end
    n_checks++;
    if (cur_vals !== 64'd0) begin n_fail++; $display("FAIL reset_vals got %h want 0", cur_vals); end
    rstn = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [63:0] exp = {16'sd123, -16'sd45, 16'sd0, 16'sd32767};
    clear_counts();
    send_line("   123    -45     0  32767\n", -1);
    n_checks++;
    if (en_cnt !== 1) begin n_fail++; $display("FAIL basic_en got %0d want 1", en_cnt); end
    n_checks++;
    if (err_cnt !== 0) begin n_fail++; $display("FAIL basic_err got %0d want 0", err_cnt); end
    n_checks++;
    if (cur_vals !== exp) begin n_fail++; $display("FAIL basic_vals got %h want %h", cur_vals, exp); end
  endtask

  task automatic test_malformed();
    logic [63:0] exp = {16'sd123, -16'sd45, 16'sd0, 16'sd32767};
    clear_counts();
    send_line("1 2 3\n", -1);
    send_line("1 2 3 4 5\n", -1);
    send_line("1 -\n", -1);
    send_line("\n", -1);
    n_checks++;
    if (err_cnt !== 4) begin n_fail++; $display("FAIL malformed_err got %0d want 4", err_cnt); end
    n_checks++;
    if (en_cnt !== 0) begin n_fail++; $display("FAIL malformed_en got %0d want 0", en_cnt); end
    n_checks++;
    if (cur_vals !== exp) begin n_fail++; $display("FAIL malformed_hold got %h want %h", cur_vals, exp); end
  endtask

  task automatic test_overflow();
`ifdef UART_CMD_RX_SAT_EN
    logic [63:0] exp = {16'sd1, 16'sd32767, -16'sd32768, 16'sd4};
`else
    logic [63:0] exp = {16'sd1, -16'sd25536, 16'sd25536, 16'sd4};
`endif
    clear_counts();
    send_line("1 40000 -40000 4\r\n", -1);
    n_checks++;
    if (en_cnt !== 1) begin n_fail++; $display("FAIL ovf_en got %0d want 1", en_cnt); end
    n_checks++;
    if (cur_vals !== exp) begin n_fail++; $display("FAIL ovf_vals got %h want %h", cur_vals, exp); end
  endtask

  task automatic test_framing();
    logic [63:0] exp = {16'sd5, 16'sd6, 16'sd7, 16'sd8};
    clear_counts();
    send_line("1 2 3 4\n", 2);
    n_checks++;
    if (err_cnt !== 1 || en_cnt !== 0) begin
      n_fail++; $display("FAIL frame_err got err=%0d en=%0d want err=1 en=0", err_cnt, en_cnt);
    end
    clear_counts();
    send_line("5 6 7 8\n", -1);
    n_checks++;
    if (en_cnt !== 1 || err_cnt !== 0) begin
      n_fail++; $display("FAIL frame_recover got en=%0d err=%0d want en=1 err=0", en_cnt, err_cnt);
    end
    n_checks++;
    if (cur_vals !== exp) begin n_fail++; $display("FAIL frame_vals got %h want %h", cur_vals, exp); end
  endtask

  task automatic test_glitch();
    logic [63:0] exp = {16'sd10, -16'sd20, 16'sd30, -16'sd40};
    clear_counts();
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    n_checks++;
    if (byte_cnt !== 0) begin n_fail++; $display("FAIL glitch_byte got %0d want 0", byte_cnt); end
    send_line("10 -20 30 -40\n", -1);
    n_checks++;
    if (en_cnt !== 1 || err_cnt !== 0) begin
      n_fail++; $display("FAIL glitch_line got en=%0d err=%0d want en=1 err=0", en_cnt, err_cnt);
    end
    n_checks++;
    if (cur_vals !== exp) begin n_fail++; $display("FAIL glitch_vals got %h want %h", cur_vals, exp); end
  endtask

  task automatic test_reset_mid_line();
    logic [63:0] exp = {16'sd1, 16'sd1, 16'sd1, 16'sd1};
    send_byte("9", 1'b1);
    send_byte(" ", 1'b1);
    send_byte("9", 1'b1);
    rx = 1'b0;
    repeat (DIV + 4) @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (cur_vals !== 64'd0 || cmd_if.o_en !== 1'b0 || cmd_if.o_err !== 1'b0) begin
      n_fail++; $display("FAIL midreset_outs got vals=%h en=%b err=%b want all 0", cur_vals, cmd_if.o_en, cmd_if.o_err);
    end
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    clear_counts();
    send_line("1 1 1 1\n", -1);
    n_checks++;
    if (en_cnt !== 1 || err_cnt !== 0) begin
      n_fail++; $display("FAIL midreset_line got en=%0d err=%0d want en=1 err=0", en_cnt, err_cnt);
    end
    n_checks++;
    if (cur_vals !== exp) begin n_fail++; $display("FAIL midreset_vals got %h want %h", cur_vals, exp); end
  endtask

  task automatic test_invariants();
    n_checks++;
    if (both_cnt !== 0) begin n_fail++; $display("FAIL en_err_overlap got %0d want 0", both_cnt); end
    n_checks++;
    if (chg_cnt !== 0) begin n_fail++; $display("FAIL val_change_without_en got %0d want 0", chg_cnt); end
  endtask

  initial begin
    rx   = 1'b1;
    rstn = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_malformed();
    test_overflow();
    test_framing();
    test_glitch();
    test_reset_mid_line();
    test_invariants();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_command_rx.md
# uart_command_rx

Receives 115200-8-N-1 UART text lines of four space-separated signed decimal integers terminated by LF, and presents them as four signed 16-bit values with a one-cycle valid pulse. It is the host-to-FPGA counterpart of the existing four-value UART monitor line format, so the same line text round-trips. It sits beside the monitor in the FOC top level and feeds set-points and debug parameters into the control path.

## Interface
- CLK_DIV, 217: clock cycles per UART bit, 16-bit; legal range 4..65535; baud = f_clk / CLK_DIV.
- rstn  in  1  asynchronous active-low reset.
- clk  in  1  the single clock.
- i_uart_rx  in  1  UART RX line, idle high, asynchronous to clk.
- o_en  out  1  one-cycle pulse when a complete, well-formed line has been accepted; reset 0.
- o_val0..o_val3  out  signed 16 each  the fields of the last good line, in line order; hold until the next good line; reset 0.
- o_err  out  1  one-cycle pulse when a line ends malformed; reset 0.

## Operation
- Byte receiver: 2-flop synchronizer, reset value 1, drives a falling-edge start detector.
  - At CLK_DIV/2 after the edge it re-samples; if the line is high, it aborts back to idle.
  - It then samples 8 data bits LSB first, each CLK_DIV apart, followed by the stop bit.
  - Stop bit = 1: emits byte + 1-cycle valid. Stop bit = 0: framing error; byte dropped, current line marked bad.
  - After the stop sample it returns to idle and needs a new falling edge.
- Byte receiver states: IDLE, START, DATA, STOP.
- Parser field state: acc (16-bit), neg, dig (digit seen), ovf (sticky), fidx (0..4), bad.
- '0'..'9':
  - acc = (acc*10 + d) mod 2^16; dig = 1.
  - ovf sets once the true magnitude exceeds 32767 (neg = 0) or 32768 (neg = 1). The check uses a 21-bit true product internally.
- '-': legal only when dig = 0 and neg = 0; sets neg. Otherwise sets bad.
- ' ' (0x20):
  - If dig = 1: commit the field to staging[fidx], increment fidx, clear acc/neg/dig/ovf.
  - If dig = 0 and neg = 1: set bad.
  - If dig = 0 and neg = 0: ignore, so leading and repeated spaces are legal.
- Commit when fidx = 4: sets bad (too many fields).
- Committed value: neg ? −acc : acc, taken mod 2^16. Saturation behaviour is covered under Configuration.
- '\r' (0x0D): ignored.
- '\n' (0x0A):
  - Commits any pending field as above.
  - If bad = 0 and fidx = 4: staging is copied to o_val0..3 and o_en pulses.
  - Otherwise o_err pulses and outputs are unchanged.
  - In both cases all line state clears.
- Any other byte: sets bad.
- An empty line (LF only) gives o_err.

## Timing
- Byte valid asserts 1 clk after the stop-bit sample point. o_en, o_err and o_val update on the following clk, 2 clk after the stop sample of '\n'.
- o_val0..3 change only in the same cycle that o_en = 1.
- o_en and o_err are never high together.
- Back-to-back bytes with zero idle time are accepted. The parser consumes one byte per clk, so there is no backpressure and no FIFO.
- Reset mid-byte or mid-line: all state returns to reset values and the partial line is lost. The first byte after release needs a fresh falling edge.
- A line held low at reset release produces no byte until the line goes high and then falls.

## Configuration
- UART_CMD_RX_SAT_EN defined: when ovf = 1, the committed value clamps to 32767 (neg = 0) or −32768 (neg = 1).
- Not defined: the value wraps mod 2^16 and the ovf flag is unused (may be optimized away).
- Either way, overflow alone never sets bad.

## Structure
- Shared package/include holds:
  - ASCII constants: 0x20, 0x2D, 0x0A, 0x0D, 0x30.
  - Parser and byte-receiver state encodings.
  - The field count (4), which is shared with the monitor line format.
- One sub-module: uart_rx_byte (synchronizer, bit timer, framing check; outputs byte, valid, frame_err).
- Parser and output registers live in uart_command_rx.

## Test plan
- CLK_DIV=16, send "   123    -45     0  32767\n" → single o_en; o_val0..3 = 123, −45, 0, 32767; o_err stays 0.
- Send "1 2 3\n", then "1 2 3 4 5\n", then "1 -\n" → three o_err pulses; o_val keeps its previous values; no o_en.
- Send "1 40000 -40000 4\r\n":
  - SAT_EN → 1, 32767, −32768, 4.
  - Without SAT_EN → 1, −25536, 25536, 4.
- Corrupt the stop bit of the '2' in "1 2 3 4\n" → o_err. Then a good "5 6 7 8\n" → o_en with 5, 6, 7, 8.
- Glitch i_uart_rx low for 3 clk (below CLK_DIV/2) → no byte produced. Then a good line → parsed correctly.
- Assert rstn mid-way through "9 9 9 9\n", release, send "1 1 1 1\n" → outputs 0 during reset, then one o_en with 1, 1, 1, 1.
